// File: rtl/elbeth_pkg.sv
// Shared opcode constants, select encodings and the decode record for the
// Elbeth pipeline control unit.
package elbeth_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        PC_PLUS4     = 2'b00,
        PC_BRANCH    = 2'b01,
        PC_JALR      = 2'b10,
        PC_EXCEPTION = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'b00,
        ALU_A_PC   = 2'b01,
        ALU_A_ZERO = 2'b10
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        ALU_B_RS2  = 2'b00,
        ALU_B_IMM  = 2'b01,
        ALU_B_FOUR = 2'b10
    } alu_b_sel_e;

    // Control-flow flags ride along with the visible fields so the PC select
    // can be derived from the registered ID instruction.
    typedef struct packed {
        alu_a_sel_e alu_a;
        alu_b_sel_e alu_b;
        logic       reg_w;
        logic       data_w_reg_select;
        logic       mem_en;
        logic       mem_rw;
        logic       data_sign_mem;
        logic       is_jal;
        logic       is_jalr;
        logic       is_branch;
    } decode_t;

    localparam decode_t DECODE_NOP = '0;

endpackage

// File: rtl/elbeth_decoder.sv
// Combinational instruction decoder: maps opcode/funct3 of the IF instruction
// onto the ID control fields. Unknown, SYSTEM and FENCE decode as NOP.
module elbeth_decoder
    import elbeth_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output decode_t    o_dec
);

    // Only funct3[2] (unsigned-load flag) affects control.
    logic w_unused_funct3;
    assign w_unused_funct3 = ^i_funct3[1:0];

    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        o_dec = DECODE_NOP;
        case (i_opcode)
            OPC_LUI: begin
                o_dec.alu_a = ALU_A_ZERO;
                o_dec.alu_b = ALU_B_IMM;
                o_dec.reg_w = 1'b1;
            end
            OPC_AUIPC: begin
                o_dec.alu_a = ALU_A_PC;
                o_dec.alu_b = ALU_B_IMM;
                o_dec.reg_w = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_dec.alu_a   = ALU_A_PC;
                o_dec.alu_b   = ALU_B_FOUR;
                o_dec.reg_w   = 1'b1;
                o_dec.is_jal  = (i_opcode == OPC_JAL);
                o_dec.is_jalr = (i_opcode == OPC_JALR);
            end
            OPC_OP: begin
                o_dec.reg_w = 1'b1;
            end
            OPC_OP_IMM: begin
                o_dec.alu_b = ALU_B_IMM;
                o_dec.reg_w = 1'b1;
            end
            OPC_LOAD: begin
                o_dec.alu_b             = ALU_B_IMM;
                o_dec.reg_w             = 1'b1;
                o_dec.data_w_reg_select = 1'b1;
                o_dec.mem_en            = 1'b1;
                o_dec.data_sign_mem     = ~i_funct3[2];
            end
            OPC_STORE: begin
                o_dec.alu_b  = ALU_B_IMM;
                o_dec.mem_en = 1'b1;
                o_dec.mem_rw = 1'b1;
            end
            OPC_BRANCH: begin
                o_dec.is_branch = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/elbeth_control_unit.sv
// Elbeth pipeline control: registered ID decode plus stall/flush/PC-select logic.
// Define ELBETH_FORWARD_EN to forward operands instead of interlocking on matches.
module elbeth_control_unit
    import elbeth_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] if_opcode,
    input  logic [2:0] if_funct3,
    input  logic       if_imem_ready,
    input  logic       if_imem_en,
    input  logic       id_match_forward_rs1,
    input  logic       id_match_forward_rs2,
    input  logic       id_branch_taken,
    input  logic       exs_dmem_ready,
    input  logic       exs_dmem_en,
    input  logic       exs_exception,
    output logic       if_stall,
    output logic       id_stall,
    output logic       if_flush,
    output logic       id_flush,
    output logic [1:0] id_pc_select,
    output logic       id_select_rs1,
    output logic       id_select_rs2,
    output logic [1:0] id_alu_port_a_select,
    output logic [1:0] id_alu_port_b_select,
    output logic       id_data_w_reg_select,
    output logic       id_reg_w,
    output logic       id_mem_en,
    output logic       id_mem_rw,
    output logic       id_data_sign_mem
);

    decode_t w_dec;
    decode_t r_id;
    pc_sel_e w_pc_select;
    logic    w_dmem_stall;
    logic    w_hazard_stall;

    elbeth_decoder u_decoder (
        .i_opcode (if_opcode),
        .i_funct3 (if_funct3),
        .o_dec    (w_dec)
    );

`ifdef ELBETH_FORWARD_EN
    assign id_select_rs1  = id_match_forward_rs1;
    assign id_select_rs2  = id_match_forward_rs2;
    assign w_hazard_stall = 1'b0;
`else
    assign id_select_rs1  = 1'b0;
    assign id_select_rs2  = 1'b0;
    assign w_hazard_stall = id_match_forward_rs1 | id_match_forward_rs2;
`endif

    assign w_dmem_stall = exs_dmem_en & ~exs_dmem_ready;
    assign id_stall     = w_dmem_stall | w_hazard_stall;
    assign if_stall     = (if_imem_en & ~if_imem_ready) | id_stall;

    always_comb begin
        w_pc_select = PC_PLUS4;
        if (exs_exception)
            w_pc_select = PC_EXCEPTION;
        else if (r_id.is_jal || (r_id.is_branch && id_branch_taken))
            w_pc_select = PC_BRANCH;
        else if (r_id.is_jalr)
            w_pc_select = PC_JALR;
    end

    // Flushes are never masked by stalls; the ID register simply holds.
    assign id_pc_select = w_pc_select;
    assign if_flush     = (w_pc_select != PC_PLUS4);
    assign id_flush     = exs_exception;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst)
            r_id <= DECODE_NOP;
        else if (!id_stall)
            r_id <= (id_flush || if_flush) ? DECODE_NOP : w_dec;
    end

    assign id_alu_port_a_select = r_id.alu_a;
    assign id_alu_port_b_select = r_id.alu_b;
    assign id_reg_w             = r_id.reg_w;
    assign id_data_w_reg_select = r_id.data_w_reg_select;
    assign id_mem_en            = r_id.mem_en;
    assign id_mem_rw            = r_id.mem_rw;
    assign id_data_sign_mem     = r_id.data_sign_mem;

endmodule

// File: tb/tb_elbeth_control_unit.sv
// Self-checking bench for elbeth_control_unit: decode table plus hazard,
// flush and reset sequences.
module tb_elbeth_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] if_opcode;
    logic [2:0] if_funct3;
    logic       if_imem_ready, if_imem_en;
    logic       id_match_forward_rs1, id_match_forward_rs2;
    logic       id_branch_taken;
    logic       exs_dmem_ready, exs_dmem_en;
    logic       exs_exception;
    logic       if_stall, id_stall, if_flush, id_flush;
    logic [1:0] id_pc_select;
    logic       id_select_rs1, id_select_rs2;
    logic [1:0] id_alu_port_a_select, id_alu_port_b_select;
    logic       id_data_w_reg_select, id_reg_w;
    logic       id_mem_en, id_mem_rw, id_data_sign_mem;

    int checks = 0;
    int errors = 0;

    elbeth_control_unit dut (
        .clk                  (clk),
        .rst                  (rst),
        .if_opcode            (if_opcode),
        .if_funct3            (if_funct3),
        .if_imem_ready        (if_imem_ready),
        .if_imem_en           (if_imem_en),
        .id_match_forward_rs1 (id_match_forward_rs1),
        .id_match_forward_rs2 (id_match_forward_rs2),
        .id_branch_taken      (id_branch_taken),
        .exs_dmem_ready       (exs_dmem_ready),
        .exs_dmem_en          (exs_dmem_en),
        .exs_exception        (exs_exception),
        .if_stall             (if_stall),
        .id_stall             (id_stall),
        .if_flush             (if_flush),
        .id_flush             (id_flush),
        .id_pc_select         (id_pc_select),
        .id_select_rs1        (id_select_rs1),
        .id_select_rs2        (id_select_rs2),
        .id_alu_port_a_select (id_alu_port_a_select),
        .id_alu_port_b_select (id_alu_port_b_select),
        .id_data_w_reg_select (id_data_w_reg_select),
        .id_reg_w             (id_reg_w),
        .id_mem_en            (id_mem_en),
        .id_mem_rw            (id_mem_rw),
        .id_data_sign_mem     (id_data_sign_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: {a[1:0], b[1:0], reg_w, wsel, mem_en, mem_rw, sign}
    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [8:0] fields;
        logic [1:0] pc;
    } vec_t;

    localparam logic [8:0] F_NOP    = 9'b00_00_00000;
    localparam logic [8:0] F_OP     = 9'b00_00_10000;
    localparam logic [8:0] F_OP_IMM = 9'b00_01_10000;
    localparam logic [8:0] F_LUI    = 9'b10_01_10000;
    localparam logic [8:0] F_STORE  = 9'b00_01_00110;

    vec_t vecs[13];

    function automatic logic [8:0] id_fields();
        return {id_alu_port_a_select, id_alu_port_b_select, id_reg_w,
                id_data_w_reg_select, id_mem_en, id_mem_rw, id_data_sign_mem};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"lui",    7'b0110111, 3'b000, 9'b10_01_10000, 2'b00};
        vecs[1]  = '{"auipc",  7'b0010111, 3'b000, 9'b01_01_10000, 2'b00};
        vecs[2]  = '{"jal",    7'b1101111, 3'b000, 9'b01_10_10000, 2'b01};
        vecs[3]  = '{"jalr",   7'b1100111, 3'b000, 9'b01_10_10000, 2'b10};
        vecs[4]  = '{"op",     7'b0110011, 3'b000, 9'b00_00_10000, 2'b00};
        vecs[5]  = '{"opimm",  7'b0010011, 3'b001, 9'b00_01_10000, 2'b00};
        vecs[6]  = '{"lw",     7'b0000011, 3'b010, 9'b00_01_11101, 2'b00};
        vecs[7]  = '{"lbu",    7'b0000011, 3'b100, 9'b00_01_11100, 2'b00};
        vecs[8]  = '{"sw",     7'b0100011, 3'b010, 9'b00_01_00110, 2'b00};
        vecs[9]  = '{"branch", 7'b1100011, 3'b000, 9'b00_00_00000, 2'b00};
        vecs[10] = '{"system", 7'b1110011, 3'b000, 9'b00_00_00000, 2'b00};
        vecs[11] = '{"fence",  7'b0001111, 3'b000, 9'b00_00_00000, 2'b00};
        vecs[12] = '{"unknown",7'b1111111, 3'b111, 9'b00_00_00000, 2'b00};

        rst = 1'b0;
        if_opcode = 7'b0110011; if_funct3 = 3'b000;
        if_imem_ready = 1'b1; if_imem_en = 1'b0;
        id_match_forward_rs1 = 1'b0; id_match_forward_rs2 = 1'b0;
        id_branch_taken = 1'b0;
        exs_dmem_ready = 1'b1; exs_dmem_en = 1'b0; exs_exception = 1'b0;
        #2;
        check("reset_fields", 32'(id_fields()), 32'(F_NOP));
        check("reset_pc", 32'(id_pc_select), 32'd0);
        check("reset_stalls", 32'({if_stall, id_stall, if_flush, id_flush}), 32'd0);
        step();
        check("reset_held", 32'(id_fields()), 32'(F_NOP));
        rst = 1'b1;
        step();
        check("reset_release_op", 32'(id_fields()), 32'(F_OP));

        // Decode table; the follow-up OP must be squashed after a redirect.
        for (int i = 0; i < 13; i++) begin
            if_opcode = vecs[i].op; if_funct3 = vecs[i].f3;
            step();
            check({"dec_", vecs[i].name}, 32'(id_fields()), 32'(vecs[i].fields));
            check({"pc_", vecs[i].name}, 32'(id_pc_select), 32'(vecs[i].pc));
            check({"ifflush_", vecs[i].name}, 32'(if_flush), 32'(vecs[i].pc != 2'b00));
            if_opcode = 7'b0110011; if_funct3 = 3'b000;
            step();
            check({"next_", vecs[i].name}, 32'(id_fields()),
                  32'((vecs[i].pc != 2'b00) ? F_NOP : F_OP));
        end

        // Instruction-memory wait stalls only IF.
        if_imem_en = 1'b1; if_imem_ready = 1'b0; #1;
        check("imem_if_stall", 32'(if_stall), 32'd1);
        check("imem_id_stall", 32'(id_stall), 32'd0);
        if_imem_ready = 1'b1; #1;
        check("imem_ready_if_stall", 32'(if_stall), 32'd0);
        if_imem_en = 1'b0;

        // Data-memory wait stalls both stages and holds ID.
        if_opcode = 7'b0010011; if_funct3 = 3'b000;
        step();
        check("pre_stall_opimm", 32'(id_fields()), 32'(F_OP_IMM));
        exs_dmem_en = 1'b1; exs_dmem_ready = 1'b0; if_opcode = 7'b0110111; #1;
        check("dmem_stalls", 32'({if_stall, id_stall}), 32'b11);
        step();
        check("dmem_hold", 32'(id_fields()), 32'(F_OP_IMM));
        exs_dmem_ready = 1'b1; #1;
        check("dmem_ready_stalls", 32'({if_stall, id_stall}), 32'b00);
        step();
        check("dmem_resume_lui", 32'(id_fields()), 32'(F_LUI));
        exs_dmem_en = 1'b0;

        // Exception during a stall: flush outputs assert, ID holds, then NOP.
        exs_dmem_en = 1'b1; exs_dmem_ready = 1'b0; exs_exception = 1'b1; #1;
        check("exc_pc", 32'(id_pc_select), 32'b11);
        check("exc_flags", 32'({if_flush, id_flush, id_stall, if_stall}), 32'b1111);
        step();
        check("exc_hold", 32'(id_fields()), 32'(F_LUI));
        exs_dmem_en = 1'b0; #1;
        check("exc_no_stall", 32'(id_stall), 32'd0);
        step();
        check("exc_nop", 32'(id_fields()), 32'(F_NOP));
        exs_exception = 1'b0; #1;
        check("exc_clear_pc", 32'(id_pc_select), 32'd0);

        // Registered branch redirect follows id_branch_taken combinationally.
        if_opcode = 7'b1100011;
        step();
        id_branch_taken = 1'b1; #1;
        check("br_taken", 32'({id_pc_select, if_flush}), 32'b011);
        id_branch_taken = 1'b0; #1;
        check("br_not_taken", 32'({id_pc_select, if_flush}), 32'b000);
        id_branch_taken = 1'b1; if_opcode = 7'b0110011;
        step();
        check("br_squash", 32'(id_fields()), 32'(F_NOP));
        check("br_squash_pc", 32'(id_pc_select), 32'd0);
        id_branch_taken = 1'b0;

        // Operand match: forward or interlock depending on build.
        step();
        check("pre_match_op", 32'(id_fields()), 32'(F_OP));
        if_opcode = 7'b0110111;
        id_match_forward_rs1 = 1'b1; #1;
`ifdef ELBETH_FORWARD_EN
        check("match_rs1", 32'({id_select_rs1, id_select_rs2, id_stall, if_stall}), 32'b1000);
        id_match_forward_rs1 = 1'b0; id_match_forward_rs2 = 1'b1; #1;
        check("match_rs2", 32'({id_select_rs1, id_select_rs2, id_stall, if_stall}), 32'b0100);
        step();
        check("match_proceed", 32'(id_fields()), 32'(F_LUI));
`else
        check("match_rs1", 32'({id_select_rs1, id_select_rs2, id_stall, if_stall}), 32'b0011);
        id_match_forward_rs1 = 1'b0; id_match_forward_rs2 = 1'b1; #1;
        check("match_rs2", 32'({id_select_rs1, id_select_rs2, id_stall, if_stall}), 32'b0011);
        step();
        check("match_hold", 32'(id_fields()), 32'(F_OP));
`endif
        id_match_forward_rs2 = 1'b0;

        // Asynchronous reset mid-operation after a STORE.
        if_opcode = 7'b0100011; if_funct3 = 3'b010;
        step();
        check("pre_rst_store", 32'(id_fields()), 32'(F_STORE));
        #1 rst = 1'b0;
        #1;
        check("async_rst", 32'(id_fields()), 32'(F_NOP));
        if_opcode = 7'b0110111; if_funct3 = 3'b000;
        step();
        rst = 1'b1; #1;
        check("rst_release_wait", 32'(id_fields()), 32'(F_NOP));
        step();
        check("rst_release_lui", 32'(id_fields()), 32'(F_LUI));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
